// File: rtl/deser_pkg.sv
// Shared constants and state type for the serial-to-parallel word assembler.
package deser_pkg;
    localparam int DATA_W_DEF  = 16;
    localparam int GAP_CYC_DEF = 8;
    localparam int CNT_W       = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;
endpackage

// File: rtl/deserializer.sv
// Assembles qualified serial bits (MSB first) into DATA_W-bit words; an idle
// gap of GAP_CYC cycles flushes a partial word left-aligned.
module deserializer
    import deser_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              data_i,
    input  logic              data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [CNT_W-1:0]  deser_mod_o,
    output logic              deser_data_val_o,
    output logic              busy_o
);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic [DATA_W-1:0]  data_reg, data_next;
    logic [CNT_W-1:0]   mod_reg, mod_next;
    logic               val_reg, val_next;
    logic               busy_reg;
    logic [DATA_W-1:0]  shifted;
    logic [DATA_W-1:0]  aligned;

    assign shifted = {shift_reg[DATA_W-2:0], data_i};
    // Partial word: push the collected bits up so the first bit lands in the MSB.
    assign aligned = shift_reg << (DATA_W - int'(cnt_reg));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gap_next   = gap_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        mod_next   = mod_reg;
        val_next   = 1'b0;
        if (data_val_i) begin
            gap_next = '0;
            if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                data_next  = shifted;
                mod_next   = CNT_W'(DATA_W);
                val_next   = 1'b1;
                state_next = IDLE;
                cnt_next   = '0;
                shift_next = '0;
            end else begin
                shift_next = shifted;
                cnt_next   = cnt_reg + CNT_W'(1);
                state_next = COLLECT;
            end
        end else if (state_reg == COLLECT) begin
            if (gap_reg == GAP_W'(GAP_CYC - 1)) begin
                data_next  = aligned;
                mod_next   = cnt_reg;
                val_next   = 1'b1;
                state_next = IDLE;
                cnt_next   = '0;
                gap_next   = '0;
                shift_next = '0;
            end else begin
                gap_next = gap_reg + GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            gap_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            mod_reg   <= '0;
            val_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            gap_reg   <= gap_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            mod_reg   <= mod_next;
            val_reg   <= val_next;
            busy_reg  <= (state_next == COLLECT);
        end
    end

    assign deser_data_o     = data_reg;
    assign deser_mod_o      = mod_reg;
    assign deser_data_val_o = val_reg;
    assign busy_o           = busy_reg;
endmodule

// File: tb/tb_deserializer.sv
// Directed and random stimulus for deserializer, checked against a bit-queue
// reference model every cycle plus fixed expectations per scenario.
module tb_deserializer;
    localparam int DW  = 16;
    localparam int GAP = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          din   = 1'b0;
    logic          dval  = 1'b0;
    logic [DW-1:0] dout;
    logic [4:0]    mod;
    logic          oval;
    logic          busy;

    deserializer #(.DATA_W(DW), .GAP_CYC(GAP)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .data_i           (din),
        .data_val_i       (dval),
        .deser_data_o     (dout),
        .deser_mod_o      (mod),
        .deser_data_val_o (oval),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0, busy_cnt = 0, idle_cnt = 0;
    bit            mq[$];
    logic [DW-1:0] e_data = '0;
    logic [4:0]    e_mod  = '0;
    logic          e_val  = 1'b0, e_busy = 1'b0;
    logic [DW-1:0] pw[$];
    int            pm[$], pc[$];
    logic          pb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: bits received so far are a queue; first bit is the MSB.
    task automatic model_emit();
        logic [DW-1:0] w = '0;
        foreach (mq[i]) w[DW-1-i] = mq[i];
        e_data = w;
        e_mod  = 5'(mq.size());
        e_val  = 1'b1;
        mq.delete();
        idle_cnt = 0;
    endtask

    task automatic step(input logic v, input logic d);
        dval = v;
        din  = d;
        @(posedge clk);
        cyc++;
        e_val = 1'b0;
        if (v) begin
            mq.push_back(d);
            idle_cnt = 0;
            if (mq.size() == DW) model_emit();
        end else if (mq.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == GAP) model_emit();
        end
        e_busy = (mq.size() > 0);
        #1;
        chk("val", 32'(oval), 32'(e_val));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("data", 32'(dout), 32'(e_data));
        chk("mod", 32'(mod), 32'(e_mod));
        if (oval === 1'b1) begin
            pw.push_back(dout);
            pm.push_back(int'(mod));
            pc.push_back(cyc);
            pb.push_back(busy);
            $display("[TB] cycle %0d word %h mod %0d", cyc, dout, mod);
        end
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic send_range(input logic [DW-1:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) step(1'b1, w[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic clear_log();
        pw.delete(); pm.delete(); pc.delete(); pb.delete();
        busy_cnt = 0;
    endtask

    // Reset is asserted between edges so the outputs must clear without a clock.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data", 32'(dout), 32'h0);
        chk("rst_mod", 32'(mod), 32'h0);
        chk("rst_val", 32'(oval), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        mq.delete();
        idle_cnt = 0;
        e_data = '0; e_mod = '0; e_val = 1'b0; e_busy = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int start, last, thresh;
        @(posedge clk);
        #1;
        do_reset();

        // Continuous word
        clear_log(); start = cyc;
        send_range(16'hA5C3, 15, 0);
        idle(10);
        chk("w1_count", pw.size(), 1);
        if (pw.size() >= 1) begin
            chk("w1_data", 32'(pw[0]), 32'hA5C3);
            chk("w1_mod", pm[0], 16);
            chk("w1_lat", pc[0] - start, 16);
        end
        chk("w1_busy_cycles", busy_cnt, 15);

        // Back-to-back words
        clear_log(); start = cyc;
        send_range(16'h1234, 15, 0);
        send_range(16'hFEDC, 15, 0);
        idle(10);
        chk("b2b_count", pw.size(), 2);
        if (pw.size() >= 2) begin
            chk("b2b_data0", 32'(pw[0]), 32'h1234);
            chk("b2b_data1", 32'(pw[1]), 32'hFEDC);
            chk("b2b_spacing", pc[1] - pc[0], 16);
            chk("b2b_first", pc[0] - start, 16);
        end

        // Gapped word, gaps shorter than the timeout
        clear_log();
        send_range(16'hBEEF, 15, 11);
        idle(3);
        send_range(16'hBEEF, 10, 5);
        idle(7);
        send_range(16'hBEEF, 4, 0);
        idle(10);
        chk("gap_count", pw.size(), 1);
        if (pw.size() >= 1) begin
            chk("gap_data", 32'(pw[0]), 32'hBEEF);
            chk("gap_mod", pm[0], 16);
        end

        // Timeout flush of a 3-bit partial word
        clear_log();
        send_range(16'hA000, 15, 13);
        last = cyc;
        idle(12);
        chk("to_count", pw.size(), 1);
        if (pw.size() >= 1) begin
            chk("to_data", 32'(pw[0]), 32'hA000);
            chk("to_mod", pm[0], 3);
            chk("to_delay", pc[0] - last, 8);
            chk("to_busy_at_pulse", 32'(pb[0]), 32'h0);
        end

        // Bit on the 8th idle cycle keeps the word alive
        clear_log();
        send_range(16'hC35A, 15, 12);
        idle(7);
        send_range(16'hC35A, 11, 0);
        idle(10);
        chk("edge_count", pw.size(), 1);
        if (pw.size() >= 1) begin
            chk("edge_data", 32'(pw[0]), 32'hC35A);
            chk("edge_mod", pm[0], 16);
        end

        // Reset mid-word discards the partial word
        clear_log();
        send_range(16'($urandom), 15, 7);
        do_reset();
        send_range(16'h0F0F, 15, 0);
        idle(10);
        chk("rst_count", pw.size(), 1);
        if (pw.size() >= 1) begin
            chk("rst_word", 32'(pw[0]), 32'h0F0F);
            chk("rst_word_mod", pm[0], 16);
        end

        // Random traffic with varying density, checked cycle by cycle
        thresh = 90;
        for (int n = 0; n < 900; n++) begin
            if (n % 60 == 0) begin
                case ($urandom_range(0, 2))
                    0:       thresh = 95;
                    1:       thresh = 50;
                    default: thresh = 8;
                endcase
            end
            step(($urandom_range(0, 99) < thresh), 1'($urandom));
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter DATA_W, default 16: output word width in bits.
REQ-002 Parameter GAP_CYC, default 8: consecutive idle cycles that close a partial word.
REQ-003 Port clk_i, input, 1: single clock; all logic rising-edge.
REQ-004 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 Port data_i, input, 1: serial bit, sampled only when data_val_i=1.
REQ-006 Port data_val_i, input, 1: qualifies data_i in the current cycle.
REQ-007 Port deser_data_o, output, DATA_W: assembled word, first-received bit in MSB.
REQ-008 Port deser_mod_o, output, 5: valid bit count of deser_data_o, range 1..DATA_W.
REQ-009 Port deser_data_val_o, output, 1: one-cycle pulse; deser_data_o and deser_mod_o are valid.
REQ-010 Port busy_o, output, 1: high while a partial word (1..DATA_W-1 bits) is held.

Function
REQ-011 The block SHALL operate in two states: IDLE (bit count 0) and COLLECT (bit count 1..DATA_W-1).
REQ-012 Each cycle with data_val_i=1, the block SHALL shift data_i into a shift register at the LSB end and increment the bit count.
REQ-013 When the DATA_W-th bit is sampled at edge N, the block SHALL drive deser_data_val_o=1 for the cycle after edge N, with deser_mod_o=DATA_W, and return to IDLE.
REQ-014 Latency SHALL be one cycle from sampling the last bit to the output pulse.
REQ-015 Cycles with data_val_i=0 in COLLECT SHALL hold the shift register and bit count and increment a gap counter.
REQ-016 Any cycle with data_val_i=1 SHALL clear the gap counter.
REQ-017 When the gap counter reaches GAP_CYC in COLLECT, the block SHALL emit the partial word for one cycle, left-aligned (first bit in MSB, unused LSBs 0), with deser_mod_o=bit count, and return to IDLE.
REQ-018 In IDLE the gap counter SHALL stay at 0, and no timeout pulse SHALL occur.
REQ-019 A valid bit arriving in the same cycle as the full-word emission SHALL start the next word with count 1, so back-to-back words need no gap.
REQ-020 If data_val_i=1 in the cycle where the gap counter would reach GAP_CYC, the block SHALL accept the bit, clear the gap counter, and emit nothing.
REQ-021 deser_data_o and deser_mod_o SHALL hold their last emitted values between pulses.
REQ-022 busy_o SHALL be registered and high exactly when the state is COLLECT.
REQ-023 The bit count SHALL be 5 bits wide, and the gap counter SHALL be $clog2(GAP_CYC+1) bits wide; neither counter SHALL wrap.

Reset
REQ-024 While rst_ni=0, the block SHALL immediately force: deser_data_o=0, deser_mod_o=0, deser_data_val_o=0, busy_o=0, state IDLE, and both counters and the shift register cleared.
REQ-025 Reset asserted mid-word SHALL discard the partial word with no emission.
REQ-026 After rst_ni deasserts, the first valid bit SHALL be bit 1 of a new word.

Structure
REQ-027 DATA_W default, GAP_CYC default, the count width, and the state enum (IDLE, COLLECT) SHALL live in shared package deser_pkg.
REQ-028 The block SHALL be a single module with no sub-module; the gap timer SHALL be inline.

Verification
REQ-029 Continuous word: 16 valid bits of 0xA5C3, MSB first, then idle -> one pulse 1 cycle after the last bit with deser_data_o=0xA5C3 and deser_mod_o=16; busy_o high for 15 cycles.
REQ-030 Back-to-back words: 32 continuous valid bits of 0x1234 then 0xFEDC -> two pulses 16 cycles apart with those values and no dropped bit.
REQ-031 Gapped word: 0xBEEF sent with a 3-cycle idle after bit 5 and a 7-cycle idle after bit 11 (GAP_CYC=8) -> single pulse with 0xBEEF and mod 16.
REQ-032 Timeout: bits 1,0,1 then idle -> pulse exactly 8 idle cycles after the last bit with deser_data_o=0xA000, deser_mod_o=3, and busy_o falling with the pulse.
REQ-033 Boundary: idle for exactly 7 cycles, then a bit on the 8th cycle -> no emission, and the word continues.
REQ-034 Reset mid-word: rst_ni low after 9 bits, then 16 bits of 0x0F0F -> no partial pulse, then one pulse with 0x0F0F and mod 16.
